memory_access_cycle: RTL and testbench

Memory-access (MA) stage of the SimpleRISC pipeline, sitting between execute and writeback. It performs `ld`/`st` against a word-addressed data memory with a configurable multi-cycle latency. It stalls upstream while an access is in flight and registers all results into the MA/RW pipeline register. Writeback consumes that register unmodified.

---
 rtl/simplerisc_pkg.sv | 24 ++
 rtl/data_memory.sv | 32 +++
 rtl/memory_access_cycle.sv | 172 +++++++++++++++++
 tb/tb_memory_access_cycle.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/simplerisc_pkg.sv
// ============================================================================
// Module      : simplerisc_pkg
// Description : Shared widths, defaults and MA-stage FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package simplerisc_pkg;

  localparam int INSTR_W         = 32;
  localparam int DATA_W          = 32;
  localparam int REG_IDX_W       = 4;
  localparam int ALU_SIG_W       = 5;
  localparam int DEFAULT_MEM_LAT = 2;
  localparam int DEFAULT_ADDR_W  = 10;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } ma_state_e;

endpackage

`default_nettype wire

// File: rtl/data_memory.sv
// ============================================================================
// Module      : data_memory
// Description : Single-port 2^ADDR_W x 32 data memory, sync write, async read.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_memory
  import simplerisc_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

`default_nettype wire

// File: rtl/memory_access_cycle.sv
// ============================================================================
// Module      : memory_access_cycle
// Description : SimpleRISC MA stage with MEM_LAT-cycle ld/st and MA/RW register.
//               Optional macro MA_RW_FWD_EN forwards RW write data into stores.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module memory_access_cycle
  import simplerisc_pkg::*;
#(
  parameter int ADDR_W  = DEFAULT_ADDR_W,
  parameter int MEM_LAT = DEFAULT_MEM_LAT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_MA,
  input  logic                 flush_MA,
  input  logic [REG_IDX_W-1:0] RS1_MA,
  input  logic [REG_IDX_W-1:0] RS2_MA,
  input  logic [REG_IDX_W-1:0] RD_MA,
  input  logic [REG_IDX_W-1:0] ra_MA,
  input  logic [DATA_W-1:0]    pc_MA,
  input  logic [DATA_W-1:0]    alu_result_MA,
  input  logic [INSTR_W-1:0]   instruction_MA,
  input  logic [DATA_W-1:0]    op2_MA,
  input  logic                 isRet_MA,
  input  logic                 isSt_MA,
  input  logic                 isWb_MA,
  input  logic                 isImmediate_MA,
  input  logic                 isBeq_MA,
  input  logic                 isBgt_MA,
  input  logic                 isUbranch_MA,
  input  logic                 isLd_MA,
  input  logic                 isCall_MA,
  input  logic [ALU_SIG_W-1:0] alusignals_MA,
  input  logic [DATA_W-1:0]    data_RW,
  input  logic [REG_IDX_W-1:0] reg_RW,
  input  logic                 iswb_RW_D,
  output logic                 stall_MA,
  output logic                 valid_RW,
  output logic [REG_IDX_W-1:0] RS1_RW,
  output logic [REG_IDX_W-1:0] RS2_RW,
  output logic [REG_IDX_W-1:0] RD_RW,
  output logic [REG_IDX_W-1:0] ra_RW,
  output logic [DATA_W-1:0]    pc_RW,
  output logic [DATA_W-1:0]    alu_result_RW,
  output logic [INSTR_W-1:0]   instruction_RW,
  output logic [DATA_W-1:0]    ldresult_RW,
  output logic                 isRet_RW,
  output logic                 isSt_RW,
  output logic                 isWb_RW,
  output logic                 isImmediate_RW,
  output logic                 isBeq_RW,
  output logic                 isBgt_RW,
  output logic                 isUbranch_RW,
  output logic                 isLd_RW,
  output logic                 isCall_RW,
  output logic [ALU_SIG_W-1:0] alusignals_RW
);

  localparam int                 c_CNT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(MEM_LAT - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

  ma_state_e          r_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic [DATA_W-1:0]  r_st_data;

  logic               w_mem_op;
  logic               w_complete;
  logic               w_take;
  logic               w_we;
  logic [ADDR_W-1:0]  w_addr;
  logic [DATA_W-1:0]  w_st_sel;
  logic [DATA_W-1:0]  w_wdata;
  logic [DATA_W-1:0]  w_rdata;

  assign w_mem_op = valid_MA & (isLd_MA | isSt_MA);
  assign w_addr   = alu_result_MA[ADDR_W+1:2];

`ifdef MA_RW_FWD_EN
  assign w_st_sel = (iswb_RW_D && (reg_RW == RD_MA)) ? data_RW : op2_MA;
`else
  logic w_unused_fwd;
  assign w_st_sel     = op2_MA;
  assign w_unused_fwd = ^{data_RW, reg_RW, iswb_RW_D};
`endif

  assign w_complete = (r_state == BUSY) ? (r_cnt == c_CNT_LAST)
                                        : (~w_mem_op | (MEM_LAT == 1));
  assign w_take     = w_complete & ~flush_MA;
  assign stall_MA   = w_mem_op & ~w_complete & ~flush_MA;

  // RW holds bubbles while BUSY, so forwarding is only valid at accept time.
  assign w_wdata = (r_state == IDLE) ? w_st_sel : r_st_data;
  assign w_we    = w_take & valid_MA & isSt_MA & ~rst;

  data_memory #(.ADDR_W(ADDR_W)) u_dmem (
    .clk     (clk),
    .i_we    (w_we),
    .i_addr  (w_addr),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= IDLE;
      r_cnt          <= '0;
      r_st_data      <= '0;
      valid_RW       <= 1'b0;
      RS1_RW         <= '0;
      RS2_RW         <= '0;
      RD_RW          <= '0;
      ra_RW          <= '0;
      pc_RW          <= '0;
      alu_result_RW  <= '0;
      instruction_RW <= '0;
      ldresult_RW    <= '0;
      alusignals_RW  <= '0;
      {isRet_RW, isSt_RW, isWb_RW, isImmediate_RW, isBeq_RW,
       isBgt_RW, isUbranch_RW, isLd_RW, isCall_RW} <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_mem_op && !flush_MA && !w_complete) begin
            r_state   <= BUSY;
            r_cnt     <= c_CNT_ONE;
            r_st_data <= w_st_sel;
          end
        end
        BUSY: begin
          if (flush_MA || w_complete) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + c_CNT_ONE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase

      valid_RW <= w_take & valid_MA;
      if (w_take) begin
        RS1_RW         <= RS1_MA;
        RS2_RW         <= RS2_MA;
        RD_RW          <= RD_MA;
        ra_RW          <= ra_MA;
        pc_RW          <= pc_MA;
        alu_result_RW  <= alu_result_MA;
        instruction_RW <= instruction_MA;
        alusignals_RW  <= alusignals_MA;
        ldresult_RW    <= (valid_MA && isLd_MA) ? w_rdata : '0;
        {isRet_RW, isSt_RW, isWb_RW, isImmediate_RW, isBeq_RW,
         isBgt_RW, isUbranch_RW, isLd_RW, isCall_RW} <=
        {isRet_MA, isSt_MA, isWb_MA, isImmediate_MA, isBeq_MA,
         isBgt_MA, isUbranch_MA, isLd_MA, isCall_MA};
      end else begin
        ldresult_RW <= '0;
        {isRet_RW, isSt_RW, isWb_RW, isImmediate_RW, isBeq_RW,
         isBgt_RW, isUbranch_RW, isLd_RW, isCall_RW} <= '0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_memory_access_cycle.sv
// ============================================================================
// Module      : tb_memory_access_cycle
// Description : Scoreboard bench for memory_access_cycle (ADDR_W=10, MEM_LAT=2).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_memory_access_cycle;

  localparam int ADDR_W  = 10;
  localparam int MEM_LAT = 2;
  localparam int F_ST = 7, F_WB = 6, F_LD = 1;
  localparam int K_ALU = 0, K_LD = 1, K_ST = 2, K_NOP = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic valid_MA, flush_MA;
  logic [3:0] RS1_MA, RS2_MA, RD_MA, ra_MA, reg_RW;
  logic [31:0] pc_MA, alu_result_MA, instruction_MA, op2_MA, data_RW;
  logic isRet_MA, isSt_MA, isWb_MA, isImmediate_MA, isBeq_MA, isBgt_MA;
  logic isUbranch_MA, isLd_MA, isCall_MA, iswb_RW_D;
  logic [4:0] alusignals_MA, alusignals_RW;
  logic stall_MA, valid_RW;
  logic [3:0] RS1_RW, RS2_RW, RD_RW, ra_RW;
  logic [31:0] pc_RW, alu_result_RW, instruction_RW, ldresult_RW;
  logic isRet_RW, isSt_RW, isWb_RW, isImmediate_RW, isBeq_RW, isBgt_RW;
  logic isUbranch_RW, isLd_RW, isCall_RW;

  always #5 clk = ~clk;

  memory_access_cycle #(.ADDR_W(ADDR_W), .MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .rst(rst), .valid_MA(valid_MA), .flush_MA(flush_MA),
    .RS1_MA(RS1_MA), .RS2_MA(RS2_MA), .RD_MA(RD_MA), .ra_MA(ra_MA),
    .pc_MA(pc_MA), .alu_result_MA(alu_result_MA), .instruction_MA(instruction_MA),
    .op2_MA(op2_MA), .isRet_MA(isRet_MA), .isSt_MA(isSt_MA), .isWb_MA(isWb_MA),
    .isImmediate_MA(isImmediate_MA), .isBeq_MA(isBeq_MA), .isBgt_MA(isBgt_MA),
    .isUbranch_MA(isUbranch_MA), .isLd_MA(isLd_MA), .isCall_MA(isCall_MA),
    .alusignals_MA(alusignals_MA), .data_RW(data_RW), .reg_RW(reg_RW),
    .iswb_RW_D(iswb_RW_D), .stall_MA(stall_MA), .valid_RW(valid_RW),
    .RS1_RW(RS1_RW), .RS2_RW(RS2_RW), .RD_RW(RD_RW), .ra_RW(ra_RW),
    .pc_RW(pc_RW), .alu_result_RW(alu_result_RW), .instruction_RW(instruction_RW),
    .ldresult_RW(ldresult_RW), .isRet_RW(isRet_RW), .isSt_RW(isSt_RW),
    .isWb_RW(isWb_RW), .isImmediate_RW(isImmediate_RW), .isBeq_RW(isBeq_RW),
    .isBgt_RW(isBgt_RW), .isUbranch_RW(isUbranch_RW), .isLd_RW(isLd_RW),
    .isCall_RW(isCall_RW), .alusignals_RW(alusignals_RW)
  );

  typedef struct {
    logic        valid;
    logic [31:0] pc, alu, ins, op2;
    logic [3:0]  rd, rs1, rs2, ra;
    logic [8:0]  flags;
    logic [4:0]  alus;
  } instr_t;

  typedef struct {
    logic [31:0] pc, alu, ins, ld;
    logic [3:0]  rd, rs1, rs2, ra;
    logic [8:0]  flags;
    logic [4:0]  alus;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mem_model [int];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc_cnt = 0;
  logic        mon_en = 1'b0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] rw_flags();
    return {isRet_RW, isSt_RW, isWb_RW, isImmediate_RW, isBeq_RW,
            isBgt_RW, isUbranch_RW, isLd_RW, isCall_RW};
  endfunction

  // Monitor: every valid RW word must match the oldest expectation.
  always @(negedge clk) begin
    if (mon_en) begin
      if (valid_RW === 1'b1) begin
        chk("output_has_expectation", {31'b0, q.size() > 0}, 32'd1);
        if (q.size() > 0) begin
          exp_t e;
          e = q.pop_front();
          chk("latency_cycle", cyc_cnt, e.cyc);
          chk("pc_RW", pc_RW, e.pc);
          chk("alu_result_RW", alu_result_RW, e.alu);
          chk("instruction_RW", instruction_RW, e.ins);
          chk("regs_RW", {RS1_RW, RS2_RW, RD_RW, ra_RW}, {e.rs1, e.rs2, e.rd, e.ra});
          chk("flags_RW", {alusignals_RW, rw_flags()}, {e.alus, e.flags});
          chk("ldresult_RW", ldresult_RW, e.ld);
        end
      end else begin
        chk("bubble_flags", {22'b0, valid_RW, rw_flags()}, 32'd0);
      end
    end
  end

  function automatic instr_t mk(input int kind, input logic [31:0] alu, input logic [31:0] op2);
    instr_t t;
    t.valid = (kind != K_NOP);
    t.pc = $urandom; t.alu = alu; t.ins = $urandom; t.op2 = op2;
    t.rd = 4'($urandom); t.rs1 = 4'($urandom); t.rs2 = 4'($urandom); t.ra = 4'($urandom);
    t.alus = 5'($urandom);
    t.flags = '0;
    case (kind)
      K_LD:    begin t.flags[F_LD] = 1'b1; t.flags[F_WB] = 1'b1; end
      K_ST:    t.flags[F_ST] = 1'b1;
      K_ALU:   begin t.flags = 9'($urandom); t.flags[F_LD] = 1'b0; t.flags[F_ST] = 1'b0; end
      default: t.flags = '0;
    endcase
    return t;
  endfunction

  task automatic drive(input instr_t t);
    valid_MA = t.valid; pc_MA = t.pc; alu_result_MA = t.alu;
    instruction_MA = t.ins; op2_MA = t.op2;
    RD_MA = t.rd; RS1_MA = t.rs1; RS2_MA = t.rs2; ra_MA = t.ra;
    alusignals_MA = t.alus;
    {isRet_MA, isSt_MA, isWb_MA, isImmediate_MA, isBeq_MA,
     isBgt_MA, isUbranch_MA, isLd_MA, isCall_MA} = t.flags;
  endtask

  task automatic drive_idle();
    instr_t t;
    t = mk(K_NOP, 32'd0, 32'd0);
    drive(t);
  endtask

  // fwd_mode: 0 = different reg, 1 = matching reg with iswb, 2 = matching reg without iswb
  task automatic issue(input instr_t t, input int fwd_mode, input logic [31:0] fwd_data,
                       input int flush_at);
    logic [31:0] sd;
    int          c, stalls, w;
    logic        s, flushed, done, mem_op;
    exp_t        e;
    drive(t);
    data_RW   = (fwd_mode == 1) ? fwd_data : $urandom;
    reg_RW    = (fwd_mode == 0) ? (t.rd ^ 4'h5) : t.rd;
    iswb_RW_D = (fwd_mode == 1) ? 1'b1 : (fwd_mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
`ifdef MA_RW_FWD_EN
    sd = (iswb_RW_D && reg_RW == t.rd) ? data_RW : t.op2;
`else
    sd = t.op2;
`endif
    w = int'((t.alu / 4) % (1 << ADDR_W));
    mem_op = t.valid && (t.flags[F_LD] || t.flags[F_ST]);
    c = 0; stalls = 0; flushed = 1'b0; done = 1'b0;
    while (!done) begin
      if (c == flush_at) flush_MA = 1'b1;
      #1 s = stall_MA;
      @(posedge clk);
      if (flush_MA) begin
        flushed = 1'b1; done = 1'b1;
      end else if (s !== 1'b1) begin
        done = 1'b1;
      end else begin
        stalls++;
      end
      if (done && !flushed) begin
        #1;
        if (t.valid) begin
          if (t.flags[F_ST]) mem_model[w] = sd;
          e.pc = t.pc; e.alu = t.alu; e.ins = t.ins;
          e.rd = t.rd; e.rs1 = t.rs1; e.rs2 = t.rs2; e.ra = t.ra;
          e.flags = t.flags; e.alus = t.alus;
          e.ld = t.flags[F_LD] ? mem_model[w] : 32'd0;
          e.cyc = cyc_cnt;
          q.push_back(e);
        end
        chk("stall_cycles", stalls, mem_op ? MEM_LAT - 1 : 0);
      end
      @(negedge clk);
      c++;
      if (!done) begin
        // Feedback changes while stalled; store data must already be latched.
        data_RW = $urandom; iswb_RW_D = 1'($urandom_range(0, 1));
      end
      if (!done && c > 40) begin
        n_cmp++; n_bad++;
        $display("FAIL stall_timeout: still stalled after %0d cycles, expected %0d", c, MEM_LAT - 1);
        done = 1'b1;
      end
    end
    flush_MA = 1'b0;
    drive_idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    instr_t t;
    int     kind, idx;
    logic [31:0] addr;
    flush_MA = 1'b0; data_RW = '0; reg_RW = '0; iswb_RW_D = 1'b0;
    drive_idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_valid_RW", {31'b0, valid_RW}, 32'd0);
    chk("reset_ldresult_RW", ldresult_RW, 32'd0);
    chk("reset_alu_result_RW", alu_result_RW, 32'd0);
    chk("reset_pc_RW", pc_RW, 32'd0);
    chk("reset_stall_MA", {31'b0, stall_MA}, 32'd0);
    mon_en = 1'b1;

    for (int i = 0; i < 16; i++) begin
      t = mk(K_ST, i * 4, $urandom);
      issue(t, 0, 32'd0, -1);
    end

    issue(mk(K_ST, 32'h10, 32'hDEADBEEF), 0, 32'd0, -1);
    issue(mk(K_LD, 32'h10, 32'd0), 0, 32'd0, -1);
    for (int i = 5; i <= 7; i++) issue(mk(K_ALU, i, 32'd0), 0, 32'd0, -1);
    issue(mk(K_ST, 32'h1000, 32'h0BADF00D), 0, 32'd0, -1);
    issue(mk(K_LD, 32'h0, 32'd0), 0, 32'd0, -1);
    issue(mk(K_ST, 32'h20, 32'h55), 0, 32'd0, 1);
    issue(mk(K_LD, 32'h20, 32'd0), 0, 32'd0, -1);
    t = mk(K_ST, 32'h28, 32'h0);
    t.rd = 4'd3;
    issue(t, 1, 32'h1234, -1);
    issue(mk(K_LD, 32'h28, 32'd0), 0, 32'd0, -1);

    // Reset in the middle of a BUSY store to word 9.
    t = mk(K_ST, 32'h24, 32'hCAFE0001);
    drive(t);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    drive_idle();
    #1;
    chk("rst_busy_valid_RW", {31'b0, valid_RW}, 32'd0);
    chk("rst_busy_ldresult_RW", ldresult_RW, 32'd0);
    chk("rst_busy_alu_result_RW", alu_result_RW, 32'd0);
    chk("rst_busy_flags_RW", {23'b0, rw_flags()}, 32'd0);
    chk("rst_busy_stall_MA", {31'b0, stall_MA}, 32'd0);
    @(negedge clk);
    issue(mk(K_LD, 32'h24, 32'd0), 0, 32'd0, -1);

    for (int i = 0; i < 250; i++) begin
      kind = $urandom_range(0, 9);
      idx  = $urandom_range(0, 15);
      addr = ($urandom & 32'hFFFF_F003) | (idx << 2);
      if (kind <= 2)      issue(mk(K_LD, addr, 32'd0), 0, 32'd0, -1);
      else if (kind <= 5) issue(mk(K_ST, addr, $urandom), $urandom_range(0, 2), $urandom, -1);
      else if (kind <= 7) issue(mk(K_ALU, $urandom, $urandom), 0, 32'd0, -1);
      else if (kind == 8) issue(mk(K_NOP, addr, $urandom), 0, 32'd0, -1);
      else issue(mk((idx[0] ? K_ST : K_LD), addr, $urandom), $urandom_range(0, 2),
                 $urandom, $urandom_range(0, MEM_LAT - 1));
    end

    repeat (4) @(negedge clk);
    chk("queue_drained", q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
